intt_sdf_stage: RTL and testbench



---
 rtl/intt_sdf_stage.sv | 151 +++++++++++++++
 tb/tb_intt_sdf_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/intt_sdf_stage.sv
// Radix-2 single-path delay-feedback inverse NTT stage (DIT butterfly).
// Twiddle multiply precedes add/sub; optional x1/2 scaling on every output.
module intt_sdf_stage #(
    parameter int W          = 32,
    parameter int MODULUS    = 7681,
    parameter int HALF       = 4,
    parameter int SCALE_HALF = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [W-1:0]            in_data,
    input  logic                    tw_we,
    input  logic [$clog2(HALF)-1:0] tw_addr,
    input  logic [W-1:0]            tw_wdata,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic                    busy
);

    localparam int AW = $clog2(HALF);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(HALF + 1);

    localparam logic [W:0]     Q1   = (W+1)'(MODULUS);
    localparam logic [2*W-1:0] Q2   = (2*W)'(MODULUS);
    localparam logic [CW-1:0]  LAST = CW'(2 * HALF - 1);
    localparam logic [PW-1:0]  FULL = PW'(HALF);

    function automatic logic [W-1:0] mod_add(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q1) begin
            s = s - Q1;
        end
        return W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W:0] r;
        if (a >= b) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, a} + Q1 - {1'b0, b};
        end
        return W'(r);
    endfunction

    // Odd residues become even by adding q, so the shift is exact.
    function automatic logic [W-1:0] halve(
        input logic [W-1:0] v
    );
        logic [W:0] s;
        s = {1'b0, v} + (v[0] ? Q1 : '0);
        return W'(s >> 1);
    endfunction

    logic [CW-1:0]  cnt;
    logic [PW-1:0]  pending;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [W-1:0]   fifo_mem [HALF];
    logic [W-1:0]   tw_mem   [HALF];

    logic           phase_b;
    logic [AW-1:0]  idx;
    logic [W-1:0]   head;
    logic [W-1:0]   tw;
    logic [2*W-1:0] prod;
    logic [W-1:0]   t;
    logic [W-1:0]   sum_val;
    logic [W-1:0]   dif_val;
    logic           take_b;
    logic           drain;
    logic           push;
    logic           pop;
    logic [W-1:0]   push_data;
    logic [W-1:0]   emit_val;
    logic [W-1:0]   scaled;

    assign phase_b = cnt[AW];
    assign idx     = cnt[AW-1:0];
    assign head    = fifo_mem[rd_ptr];
    assign tw      = tw_mem[idx];

    assign prod    = (2*W)'(tw) * (2*W)'(in_data);
    assign t       = W'(prod % Q2);
    assign sum_val = mod_add(head, t);
    assign dif_val = mod_sub(head, t);

    // Phase A drains stored differences; phase B consumes stored x[j].
    assign take_b    = phase_b && in_valid;
    assign drain     = !phase_b && (pending != '0);
    assign push      = in_valid;
    assign pop       = take_b || drain;
    assign push_data = phase_b ? dif_val : in_data;
    assign emit_val  = phase_b ? sum_val : head;
    assign scaled    = (SCALE_HALF != 0) ? halve(emit_val) : emit_val;

    assign busy = (cnt != '0) || (pending != '0);

    always_ff @(posedge clk) begin
        if (tw_we) begin
            tw_mem[tw_addr] <= tw_wdata;
        end
    end

    // Storage is left unreset; emptiness is carried by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            pending   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (in_valid) begin
                cnt <= cnt + CW'(1);
            end
            if (take_b && cnt == LAST) begin
                pending <= FULL;
            end else if (drain) begin
                pending <= pending - PW'(1);
            end
            out_valid <= pop;
            if (pop) begin
                out_data <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_intt_sdf_stage.sv
// Scoreboard bench for intt_sdf_stage: unscaled and scaled instances
// driven in parallel, each with its own expected-output queue.
module tb_intt_sdf_stage;

    localparam int W = 32;
    localparam int H = 2;

    typedef struct {
        logic [W-1:0] d;
        bit           adj;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         tw_we;
    logic [0:0]   tw_addr;
    logic [W-1:0] tw_wdata;
    logic         out_valid0;
    logic [W-1:0] out_data0;
    logic         busy0;
    logic         out_valid1;
    logic [W-1:0] out_data1;
    logic         busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last0  = 0;
    int   last1  = 0;

    int blk8[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int r0[8]   = '{4, 10, 7679, 7675, 12, 22, 7679, 7671};
    int r1[8]   = '{2, 5, 7680, 7678, 6, 11, 7680, 7676};

    intt_sdf_stage #(
        .W(W), .MODULUS(7681), .HALF(H), .SCALE_HALF(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .tw_we(tw_we), .tw_addr(tw_addr), .tw_wdata(tw_wdata),
        .out_valid(out_valid0), .out_data(out_data0), .busy(busy0)
    );

    intt_sdf_stage #(
        .W(W), .MODULUS(7681), .HALF(H), .SCALE_HALF(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .tw_we(tw_we), .tw_addr(tw_addr), .tw_wdata(tw_wdata),
        .out_valid(out_valid1), .out_data(out_data1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ex(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit adj);
        q0.push_back('{a, adj});
        q1.push_back('{b, adj});
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tw_write(input logic a, input logic [W-1:0] d);
        tw_we    = 1'b1;
        tw_addr  = a;
        tw_wdata = d;
        @(posedge clk);
        #1;
        tw_we = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++)
            step(1'b0, '0);
        chk({name, " dut0 pending outputs"}, q0.size(), 0);
        chk({name, " dut1 pending outputs"}, q1.size(), 0);
        step(1'b0, '0);
        step(1'b0, '0);
        chk({name, " busy0 idle"}, busy0, 1'b0);
        chk({name, " busy1 idle"}, busy1, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc = cyc + 1;
        if (!rst && out_valid0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected output: got %0d", out_data0);
            end else begin
                e = q0.pop_front();
                chk("dut0 data", out_data0, e.d);
                if (e.adj) chk("dut0 adjacency", cyc, last0 + 1);
            end
            last0 = cyc;
        end
        if (!rst && out_valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected output: got %0d", out_data1);
            end else begin
                e = q1.pop_front();
                chk("dut1 data", out_data1, e.d);
                if (e.adj) chk("dut1 adjacency", cyc, last1 + 1);
            end
            last1 = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tw_we    = 1'b0;
        tw_addr  = '0;
        tw_wdata = '0;
        #12;
        chk("reset out_valid0", out_valid0, 1'b0);
        chk("reset out_data0", out_data0, 0);
        chk("reset busy0", busy0, 1'b0);
        chk("reset out_valid1", out_valid1, 1'b0);
        chk("reset busy1", busy1, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic block, then idle drain
        tw_write(1'b0, 1);
        tw_write(1'b1, 2);
        for (int i = 0; i < 4; i++) ex(r0[i], r1[i], i != 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, blk8[i]);
            if (i == 2) begin
                chk("first sum latency valid", out_valid0, 1'b1);
                chk("first sum latency data", out_data0, 4);
            end
        end
        step(1'b0, '0);
        chk("busy during drain", busy0, 1'b1);
        wait_drain("basic");

        // Wrap-around arithmetic
        tw_write(1'b0, 7680);
        tw_write(1'b1, 7680);
        ex(0, 0, 0);
        ex(0, 0, 1);
        ex(7679, 7680, 1);
        ex(7679, 7680, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 7680);
        wait_drain("wrap");

        // Back-to-back blocks, continuous output
        tw_write(1'b0, 1);
        tw_write(1'b1, 2);
        for (int i = 0; i < 8; i++) ex(r0[i], r1[i], i != 0);
        for (int i = 0; i < 8; i++) step(1'b1, blk8[i]);
        wait_drain("b2b");

        // Alternating gaps
        for (int i = 0; i < 8; i++) ex(r0[i], r1[i], 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, blk8[i]);
            step(1'b0, '0);
            if (i == 2) chk("no output in phase-B stall", out_valid0, 1'b0);
            if (i == 3) chk("drain during gap", out_valid0, 1'b1);
        end
        wait_drain("gaps");

        // Async reset mid-block
        step(1'b1, 1);
        step(1'b1, 2);
        chk("busy before reset", busy0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset out_valid0", out_valid0, 1'b0);
        chk("async reset busy0", busy0, 1'b0);
        chk("async reset busy1", busy1, 1'b0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ex(r0[i], r1[i], i != 0);
        for (int i = 0; i < 4; i++) step(1'b1, blk8[i]);
        wait_drain("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
